muxn_skid_reg: RTL and testbench

//  Parametrised N:1 select feeding a registered 2-entry skid buffer with valid/ready handshake.

---
 rtl/mux_pkg.sv | 17 +
 rtl/muxn1.sv | 27 ++
 rtl/muxn_skid_reg.sv | 119 +++++++++++
 tb/tb_muxn_skid_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 select / skid-buffer blocks: occupancy encodings
// and the select-width helper.
package mux_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Bits needed to index n inputs, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/muxn1.sv
// Combinational N:1 select over a packed input bus; out-of-range selects yield zero
// data and raise sel_err_o.
module muxn1
    import mux_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int NUM_IN   = 4,
    localparam int SEL_WIDTH = clog2(NUM_IN)
) (
    input  logic [NUM_IN*IN_WIDTH-1:0] in_data_i,
    input  logic [SEL_WIDTH-1:0]       sel_i,
    output logic [IN_WIDTH-1:0]        data_o,
    output logic                       sel_err_o
);

    always_comb begin
        data_o    = '0;
        sel_err_o = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == k[SEL_WIDTH-1:0]) begin
                data_o    = in_data_i[k*IN_WIDTH +: IN_WIDTH];
                sel_err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_skid_reg.sv
// N:1 select captured into a two-entry registered skid buffer with valid/ready
// handshake and flush; in_ready depends only on registered occupancy.
module muxn_skid_reg
    import mux_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int NUM_IN   = 4,
    localparam int SEL_WIDTH = clog2(NUM_IN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN*IN_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]       sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [IN_WIDTH-1:0]        out_data,
    output logic                       out_err,
    output logic                       out_valid,
    input  logic                       out_ready
);

    logic [IN_WIDTH-1:0] mux_data;
    logic                mux_err;

    logic [1:0]          state_q, state_d;
    logic [IN_WIDTH-1:0] main_data_q, main_data_d;
    logic                main_err_q, main_err_d;
    logic [IN_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                skid_err_q, skid_err_d;

    muxn1 #(
        .IN_WIDTH (IN_WIDTH),
        .NUM_IN   (NUM_IN)
    ) u_mux (
        .in_data_i (in_data),
        .sel_i     (sel),
        .data_o    (mux_data),
        .sel_err_o (mux_err)
    );

    // Outside TWO the block is always ready, so in_valid alone means a transfer in.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_err_d  = 1'b0;
            skid_data_d = '0;
            skid_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d     = ST_ONE;
                        main_data_d = mux_data;
                        main_err_d  = mux_err;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        main_data_d = mux_data;
                        main_err_d  = mux_err;
                    end else if (in_valid) begin
                        state_d     = ST_TWO;
                        skid_data_d = mux_data;
                        skid_err_d  = mux_err;
                    end else if (out_ready) begin
                        state_d     = ST_EMPTY;
                        main_data_d = '0;
                        main_err_d  = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                        skid_data_d = '0;
                        skid_err_d  = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = '0;
                    main_err_d  = 1'b0;
                    skid_data_d = '0;
                    skid_err_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign in_ready  = (state_q != ST_TWO);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_muxn_skid_reg.sv
// Bench for muxn_skid_reg: directed handshake/flush/reset/range cases and a random
// run, all scored against an occupancy queue model.
module tb_muxn_skid_reg;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  sel;
    logic        in_valid, in_ready, flush;
    logic [15:0] out_data;
    logic        out_err, out_valid, out_ready;

    logic [47:0] in_data3;
    logic [1:0]  sel3;
    logic        in_valid3, in_ready3, flush3;
    logic [15:0] out_data3;
    logic        out_err3, out_valid3, out_ready3;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;
    logic [16:0] sb_q[$];

    muxn_skid_reg #(.IN_WIDTH(16), .NUM_IN(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    muxn_skid_reg #(.IN_WIDTH(16), .NUM_IN(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .flush     (flush3),
        .out_data  (out_data3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {err, data} for a 4-input select.
    function automatic logic [16:0] model_sel(input logic [63:0] d, input logic [1:0] s);
        logic [15:0] lanes [4];
        for (int k = 0; k < 4; k++) lanes[k] = d[k*16 +: 16];
        return {1'b0, lanes[s]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Decides, between edges, what the coming edge will do to the model.
    always @(negedge clk) begin
        if (!mon_en) begin
            sb_q.delete();
        end else begin
            int sz;
            sz = sb_q.size();
            check_eq("mon_out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
            check_eq("mon_in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
            if (sz != 0) begin
                check_eq("mon_out_word", {15'd0, out_err, out_data}, {15'd0, sb_q[0]});
            end else begin
                check_eq("mon_idle_zero", {15'd0, out_err, out_data}, 32'd0);
            end
            if (sz != 0 && out_ready) void'(sb_q.pop_front());
            if (flush) sb_q.delete();
            else if (in_valid && sz < 2) sb_q.push_back(model_sel(in_data, sel));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data3 = '0; sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
        repeat (3) cyc();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        check_eq("rst3_out_valid", {31'd0, out_valid3}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc();
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming with out_ready high
        out_ready = 1'b1;
        in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_w;
            sel = i[1:0];
            in_valid = 1'b1;
            check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
            cyc();
            exp_w = in_data[i*16 +: 16];
            check_eq("stream_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stream_data", {16'd0, out_data}, {16'd0, exp_w});
        end
        in_valid = 1'b0;
        cyc();
        check_eq("stream_drained", {31'd0, out_valid}, 32'd0);
        check_eq("stream_drained_data", {16'd0, out_data}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        sel = 2'd0;
        in_data = {48'd0, 16'hAAAA};
        in_valid = 1'b1;
        cyc();
        check_eq("bp_one_in_ready", {31'd0, in_ready}, 32'd1);
        in_data = {48'd0, 16'hBBBB};
        cyc();
        check_eq("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_hold_a", {16'd0, out_data}, 32'h0000AAAA);
        in_data = {48'd0, 16'hCCCC};
        cyc();
        check_eq("bp_hold_a2", {16'd0, out_data}, 32'h0000AAAA);
        check_eq("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        check_eq("bp_b_next", {16'd0, out_data}, 32'h0000BBBB);
        check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
        cyc();
        check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

        // Range check on a 3-input instance
        out_ready3 = 1'b1;
        in_data3 = {16'h3C3C, 16'h2B2B, 16'h1A1A};
        sel3 = 2'd3;
        in_valid3 = 1'b1;
        cyc();
        check_eq("range_valid", {31'd0, out_valid3}, 32'd1);
        check_eq("range_data", {16'd0, out_data3}, 32'd0);
        check_eq("range_err", {31'd0, out_err3}, 32'd1);
        sel3 = 2'd2;
        cyc();
        check_eq("range_ok_data", {16'd0, out_data3}, 32'h00003C3C);
        check_eq("range_ok_err", {31'd0, out_err3}, 32'd0);
        in_valid3 = 1'b0;

        // Flush in TWO with input offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {48'd0, 16'hDDDD};
        cyc();
        in_data = {48'd0, 16'hEEEE};
        cyc();
        check_eq("flush_pre_two", {31'd0, in_ready}, 32'd0);
        in_data = {48'd0, 16'hFFFF};
        flush = 1'b1;
        cyc();
        check_eq("flush_two_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_two_ready", {31'd0, in_ready}, 32'd1);
        check_eq("flush_two_data", {16'd0, out_data}, 32'd0);
        // Flush in ONE while a transfer in is accepted: that word is dropped too
        flush = 1'b0;
        in_data = {48'd0, 16'h1234};
        cyc();
        flush = 1'b1;
        in_data = {48'd0, 16'h5678};
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        check_eq("flush_one_gone", {31'd0, out_valid}, 32'd0);

        // Reset in TWO
        in_valid = 1'b1;
        in_data = {48'd0, 16'h0F0F};
        cyc();
        cyc();
        check_eq("rst_mid_two", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mid_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_mid_empty", {31'd0, out_valid}, 32'd0);
        mon_en = 1'b1;

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 31) == 0;
            sel       = 2'($urandom_range(0, 3));
            in_data   = {$urandom(), $urandom()};
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check_eq("drain_queue", sb_q.size(), 32'd0);
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
